// File: rtl/mat4_stream_mac.sv
// mat4_stream_mac: streaming 4x4 vector-matrix multiply-accumulate.
// Loads a 4-element vector serially and computes one result row per cycle
// using four multipliers. It then returns the four results serially.
// Optional build macro MAT4_STREAM_SAT_EN: saturate each result to
// 2^DATA_W-1 instead of truncating it modulo 2^DATA_W.
module mat4_stream_mac #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 2 * DATA_W + 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int unsigned N_ELEM = 4;
    localparam int unsigned N_COEF = 16;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        OUT     = 2'd2
    } state_e;

    state_e            state_q;
    logic [1:0]        cnt_q;
    logic [1:0]        row_q;
    logic [1:0]        idx_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_last_q;
    logic              busy_q;

    logic [DATA_W-1:0] coef_q [N_COEF];
    logic [DATA_W-1:0] vec_q  [N_ELEM];
    logic [DATA_W-1:0] res_q  [N_ELEM];

    logic [ACC_W-1:0]  acc_c;
    logic [DATA_W-1:0] row_res_c;

    assign busy      = busy_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

    // Dot product of the stored vector with the current coefficient row.
    always_comb begin
        acc_c = '0;
        for (int c = 0; c < int'(N_ELEM); c++) begin
            acc_c = acc_c + ACC_W'(vec_q[c]) * ACC_W'(coef_q[{row_q, 2'(c)}]);
        end
    end

`ifdef MAT4_STREAM_SAT_EN
    localparam logic [DATA_W-1:0] SAT_MAX = '1;

    // Clamp the full-precision sum to the largest representable result.
    always_comb begin
        row_res_c = DATA_W'(acc_c);
        if (acc_c > ACC_W'(SAT_MAX)) begin
            row_res_c = SAT_MAX;
        end
    end
`else
    // Keep the low DATA_W bits of the sum (modulo 2^DATA_W).
    always_comb begin
        row_res_c = DATA_W'(acc_c);
    end
`endif

    // Control FSM: LOAD -> COMPUTE (4 rows) -> OUT (4 results) -> LOAD.
    // The output flags are registered and updated with each state move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            cnt_q       <= 2'd0;
            row_q       <= 2'd0;
            idx_q       <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        busy_q <= 1'b1;
                        if (cnt_q == 2'd3) begin
                            state_q    <= COMPUTE;
                            cnt_q      <= 2'd0;
                            in_ready_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end
                end
                COMPUTE: begin
                    if (row_q == 2'd3) begin
                        // Result 0 was stored three edges ago, so it can be presented now.
                        state_q     <= OUT;
                        row_q       <= 2'd0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= res_q[0];
                        out_last_q  <= 1'b0;
                    end else begin
                        row_q <= row_q + 2'd1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        if (idx_q == 2'd3) begin
                            state_q     <= LOAD;
                            idx_q       <= 2'd0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            in_ready_q  <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            idx_q      <= idx_q + 2'd1;
                            out_data_q <= res_q[idx_q + 2'd1];
                            out_last_q <= (idx_q == 2'd2);
                        end
                    end
                end
                default: begin
                    state_q     <= LOAD;
                    cnt_q       <= 2'd0;
                    row_q       <= 2'd0;
                    idx_q       <= 2'd0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Coefficient store; writes are accepted only while idle so that the
    // matrix stays frozen for a whole transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_COEF); i++) begin
                coef_q[i] <= '0;
            end
        end else if (cfg_we && !busy_q) begin
            coef_q[cfg_addr] <= cfg_data;
        end
    end

    // Capture each accepted vector element into its slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_ELEM); i++) begin
                vec_q[i] <= '0;
            end
        end else if ((state_q == LOAD) && in_valid) begin
            vec_q[cnt_q] <= in_data;
        end
    end

    // Register one result row per COMPUTE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_ELEM); i++) begin
                res_q[i] <= '0;
            end
        end else if (state_q == COMPUTE) begin
            res_q[row_q] <= row_res_c;
        end
    end

endmodule

// File: tb/tb_mat4_stream_mac.sv
// Directed testbench for mat4_stream_mac (expected values follow
// MAT4_STREAM_SAT_EN when the bench is built with that macro).
module tb_mat4_stream_mac;

    logic       clk;
    logic       rst_n;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       busy;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    int checks;
    int errors;

    logic [7:0] mat [16];
    logic [7:0] vec_in [4];
    logic [7:0] got_data [4];
    logic       got_last [4];

    mat4_stream_mac dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic load_matrix();
        for (int i = 0; i < 16; i++) begin
            cfg_write(4'(i), mat[i]);
        end
    endtask

    task automatic set_identity();
        for (int i = 0; i < 16; i++) begin
            mat[i] = ((i / 4) == (i % 4)) ? 8'd1 : 8'd0;
        end
    endtask

    // Streams the first n elements of vec_in; returns at the negedge after the last capture.
    task automatic send(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = vec_in[i];
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Collects n results with out_ready held high.
    task automatic recv(input int n);
        int w;
        out_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            w = 0;
            while (!out_valid && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (!out_valid) begin
                checks++;
                errors++;
                $display("FAIL recv_timeout result %0d: out_valid=%b required 1", k, out_valid);
            end
            got_data[k] = out_data;
            got_last[k] = out_last;
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL reset_out_data: got %0d required 0", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b required 0", out_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    endtask

    task automatic test_identity();
        int n;
        set_identity();
        load_matrix();
        vec_in = '{8'd1, 8'd2, 8'd3, 8'd4};
        send(4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ident_busy: got %b required 1", busy); end
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL ident_latency: got %0d edges required 4", n); end
        recv(4);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got_data[k] !== 8'(k + 1) || got_last[k] !== (k == 3)) begin
                errors++;
                $display("FAIL ident_out%0d: got %0d last %b required %0d last %b",
                         k, got_data[k], got_last[k], k + 1, (k == 3));
            end
        end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL ident_idle: busy %b in_ready %b required 0 1", busy, in_ready); end
    endtask

    task automatic test_rows();
        logic [7:0] exp [4];
`ifdef MAT4_STREAM_SAT_EN
        exp = '{8'd100, 8'd200, 8'd255, 8'd255};
`else
        exp = '{8'd100, 8'd200, 8'd44, 8'd144};
`endif
        for (int i = 0; i < 16; i++) mat[i] = 8'((i / 4) + 1);
        load_matrix();
        vec_in = '{8'd10, 8'd20, 8'd30, 8'd40};
        send(4);
        recv(4);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got_data[k] !== exp[k]) begin errors++; $display("FAIL rows_out%0d: got %0d required %0d", k, got_data[k], exp[k]); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
`ifdef MAT4_STREAM_SAT_EN
        exp = 8'd255;
`else
        exp = 8'd0;
`endif
        for (int i = 0; i < 16; i++) mat[i] = 8'd16;
        load_matrix();
        vec_in = '{8'd16, 8'd16, 8'd16, 8'd16};
        send(4);
        recv(4);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got_data[k] !== exp) begin errors++; $display("FAIL ovf_out%0d: got %0d required %0d", k, got_data[k], exp); end
        end
    endtask

    task automatic test_cfg_frozen();
        set_identity();
        load_matrix();
        vec_in = '{8'd1, 8'd2, 8'd3, 8'd4};
        send(4);
        cfg_write(4'd0, 8'd9);
        recv(4);
        checks++; if (got_data[0] !== 8'd1) begin errors++; $display("FAIL frozen_o1: got %0d required 1", got_data[0]); end
        cfg_write(4'd0, 8'd9);
        send(4);
        recv(4);
        checks++; if (got_data[0] !== 8'd9) begin errors++; $display("FAIL idle_write_o1: got %0d required 9", got_data[0]); end
        checks++; if (got_data[3] !== 8'd4) begin errors++; $display("FAIL idle_write_o4: got %0d required 4", got_data[3]); end
    endtask

    task automatic test_backpressure();
        int w;
        set_identity();
        load_matrix();
        vec_in = '{8'd5, 8'd6, 8'd7, 8'd8};
        send(4);
        w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++; if (out_data !== 8'd5) begin errors++; $display("FAIL bp_o1: got %0d required 5", out_data); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'd6 || in_ready !== 1'b0 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid %b data %0d in_ready %b last %b required 1 6 0 0",
                         c, out_valid, out_data, in_ready, out_last);
            end
            @(negedge clk);
        end
        recv(3);
        checks++;
        if (got_data[0] !== 8'd6 || got_data[1] !== 8'd7 || got_data[2] !== 8'd8 || got_last[2] !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain: got %0d %0d %0d last %b required 6 7 8 last 1",
                     got_data[0], got_data[1], got_data[2], got_last[2]);
        end
    endtask

    task automatic test_reset_mid();
        set_identity();
        load_matrix();
        vec_in = '{8'd1, 8'd2, 8'd3, 8'd4};
        send(2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b required 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'd0 || out_last !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: in_ready %b out_valid %b out_data %0d out_last %b busy %b required 1 0 0 0 0",
                     in_ready, out_valid, out_data, out_last, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(4);
        recv(4);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got_data[k] !== 8'd0) begin errors++; $display("FAIL mid_fresh_out%0d: got %0d required 0", k, got_data[k]); end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = 4'd0;
        cfg_data  = 8'd0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b0;

        test_reset();
        test_identity();
        test_rows();
        test_overflow();
        test_cfg_frozen();
        test_backpressure();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
